// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: prioritises memory wait, taken branch and load-use
// into stall/flush strobes, tracks memory-wait timeouts and counts stall cycles.
module pipe_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic       ex_is_load,
  input  logic       ex_gpr_we_,
  input  logic [4:0] ex_dst_addr,
  input  logic       ex_branch_taken,
  input  logic       mem_req,
  input  logic       mem_ack,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       id_ex_stall,
  output logic       ex_mem_stall,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       mem_wb_flush,
  output logic [1:0] state,
  output logic       mem_err,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  state_t      state_q;
  logic [7:0]  wait_cnt_q;
  logic        mem_err_q;
  logic [15:0] stall_cnt_q;

  logic mem_wait;
  logic rs1_hit;
  logic rs2_hit;
  logic load_use;

  assign mem_wait = mem_req & ~mem_ack & (state_q != ERR);
  assign rs1_hit  = id_rs1_used & (id_rs1_addr == ex_dst_addr);
  assign rs2_hit  = id_rs2_used & (id_rs2_addr == ex_dst_addr);
  // x0 is never a real destination, so it can never create a hazard.
  assign load_use = ex_is_load & ~ex_gpr_we_ & (ex_dst_addr != 5'd0) & (rs1_hit | rs2_hit);

  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    if (!reset) begin
      if (state_q == ERR || mem_wait) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_flush = 1'b1;
      end else if (ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      wait_cnt_q  <= 8'd0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      if (pc_stall && stall_cnt_q != 16'hFFFF) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      case (state_q)
        RUN: begin
          if (mem_wait) begin
            state_q    <= MEM_WAIT;
            wait_cnt_q <= 8'd0;
          end
        end
        MEM_WAIT: begin
          if (!mem_wait) begin
            state_q <= RUN;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
            // Counter is about to reach 255 with no ack: the access is lost.
            if (wait_cnt_q == 8'd254) begin
              state_q   <= ERR;
              mem_err_q <= 1'b1;
            end
          end
        end
        ERR: begin
          mem_err_q <= 1'b1;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  assign state     = state_q;
  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a priority-table/episode model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  id_rs1_addr, id_rs2_addr, ex_dst_addr;
  logic        id_rs1_used, id_rs2_used, ex_is_load, ex_gpr_we_;
  logic        ex_branch_taken, mem_req, mem_ack;
  logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic        if_id_flush, id_ex_flush, mem_wb_flush;
  logic [1:0]  state;
  logic        mem_err;
  logic [15:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  pipe_ctrl dut (
    .clk(clk), .reset(reset),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_is_load(ex_is_load), .ex_gpr_we_(ex_gpr_we_), .ex_dst_addr(ex_dst_addr),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_mem_stall(ex_mem_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_flush(mem_wb_flush), .state(state), .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  // Model: an error latch, whether a wait episode is open, how many wait cycles
  // that episode has consumed, and the saturating stall total.
  bit m_err;
  bit m_waiting;
  int m_wait_cycles;
  int m_stall;

  // Expected strobes {pc, if_id_s, id_ex_s, ex_mem_s, if_id_f, id_ex_f, mem_wb_f}.
  function automatic logic [6:0] exp_ctl();
    logic hit;
    if (reset) return 7'b0000000;
    if (m_err) return 7'b1111001;
    if (mem_req && !mem_ack) return 7'b1111001;
    if (ex_branch_taken) return 7'b0000110;
    hit = ex_is_load && !ex_gpr_we_ && ex_dst_addr != 5'd0 &&
          ((id_rs1_used && id_rs1_addr == ex_dst_addr) ||
           (id_rs2_used && id_rs2_addr == ex_dst_addr));
    if (hit) return 7'b1100010;
    return 7'b0000000;
  endfunction

  function automatic logic exp_pc_stall();
    logic [6:0] v;
    v = exp_ctl();
    return v[6];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_err         <= 1'b0;
      m_waiting     <= 1'b0;
      m_wait_cycles <= 0;
      m_stall       <= 0;
    end else begin
      if (exp_pc_stall() && m_stall < 65535) m_stall <= m_stall + 1;
      if (!m_err) begin
        if (mem_req && !mem_ack) begin
          m_waiting     <= 1'b1;
          m_wait_cycles <= m_wait_cycles + 1;
          if (m_wait_cycles + 1 >= 256) m_err <= 1'b1;
        end else begin
          m_waiting     <= 1'b0;
          m_wait_cycles <= 0;
        end
      end
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    check("ctl", {25'd0, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                  if_id_flush, id_ex_flush, mem_wb_flush}, {25'd0, exp_ctl()});
    check("state", {30'd0, state}, m_err ? 32'd2 : (m_waiting ? 32'd1 : 32'd0));
    check("mem_err", {31'd0, mem_err}, {31'd0, m_err});
    check("stall_cnt", {16'd0, stall_cnt}, m_stall);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_is_load = 1'b0; ex_gpr_we_ = 1'b1; ex_dst_addr = 5'd0;
    ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic load_use_pat(input logic [4:0] dst);
    ex_is_load = 1'b1; ex_gpr_we_ = 1'b0; ex_dst_addr = dst;
    id_rs2_used = 1'b1; id_rs2_addr = dst;
  endtask

  initial begin
    idle();
    load_use_pat(5'd5);
    mem_req = 1'b1;
    tick(2); #1;
    check("rst_pc_stall", pc_stall, 0);
    check("rst_mem_wb_flush", mem_wb_flush, 0);
    check("rst_state", state, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    reset = 1'b0;
    idle();
    tick(1);

    // Load-use on rs2.
    load_use_pat(5'd5); #1;
    check("lu_pc_stall", pc_stall, 1);
    check("lu_if_id_stall", if_id_stall, 1);
    check("lu_id_ex_flush", id_ex_flush, 1);
    check("lu_id_ex_stall", id_ex_stall, 0);
    tick(1); idle(); #1;
    check("lu_stall_cnt", stall_cnt, 1);
    check("lu_released", pc_stall, 0);

    // x0 destination, unused source, no write, then branch priority.
    load_use_pat(5'd0); #1;
    check("x0_no_stall", pc_stall, 0);
    load_use_pat(5'd7); id_rs2_used = 1'b0; id_rs1_addr = 5'd7; #1;
    check("unused_src_no_stall", pc_stall, 0);
    load_use_pat(5'd7); ex_gpr_we_ = 1'b1; #1;
    check("no_write_no_stall", pc_stall, 0);
    load_use_pat(5'd5); ex_branch_taken = 1'b1; #1;
    check("br_if_id_flush", if_id_flush, 1);
    check("br_id_ex_flush", id_ex_flush, 1);
    check("br_pc_stall", pc_stall, 0);
    tick(1); idle(); #1;
    check("br_stall_cnt", stall_cnt, 1);

    // Three-cycle memory wait, ack on the fourth cycle; load-use is overridden.
    mem_req = 1'b1; load_use_pat(5'd5); #1;
    check("mw1_strobes", {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_flush}, 5'b11111);
    check("mw1_id_ex_flush", id_ex_flush, 0);
    check("mw1_state", state, 0);
    tick(1);
    check("mw2_state", state, 1);
    check("mw2_pc_stall", pc_stall, 1);
    tick(1);
    check("mw3_state", state, 1);
    tick(1); mem_ack = 1'b1; idle(); mem_req = 1'b1; mem_ack = 1'b1; #1;
    check("ack_pc_stall", pc_stall, 0);
    check("ack_mem_wb_flush", mem_wb_flush, 0);
    check("ack_state", state, 1);
    tick(1); idle(); #1;
    check("mw_done_state", state, 0);
    check("mw_stall_cnt", stall_cnt, 4);

    // Same-cycle ack needs no stall.
    mem_req = 1'b1; mem_ack = 1'b1; #1;
    check("fast_ack_pc_stall", pc_stall, 0);
    tick(1); idle(); #1;
    check("fast_ack_state", state, 0);
    check("fast_ack_stall_cnt", stall_cnt, 4);

    // Branch pending across a two-cycle wait.
    mem_req = 1'b1; ex_branch_taken = 1'b1; #1;
    check("pb1_if_id_flush", if_id_flush, 0);
    check("pb1_pc_stall", pc_stall, 1);
    tick(1);
    check("pb2_id_ex_flush", id_ex_flush, 0);
    check("pb2_state", state, 1);
    tick(1); mem_ack = 1'b1; #1;
    check("pb_ack_if_id_flush", if_id_flush, 1);
    check("pb_ack_id_ex_flush", id_ex_flush, 1);
    check("pb_ack_pc_stall", pc_stall, 0);
    tick(1); idle(); #1;
    check("pb_after_flush", if_id_flush, 0);
    check("pb_stall_cnt", stall_cnt, 6);

    // Asynchronous reset in the middle of a wait.
    mem_req = 1'b1;
    tick(2);
    check("mid_wait_state", state, 1);
    reset = 1'b1; #1;
    check("mid_rst_state", state, 0);
    check("mid_rst_pc_stall", pc_stall, 0);
    check("mid_rst_stall_cnt", stall_cnt, 0);
    tick(1); reset = 1'b0; idle();
    tick(1);

    // Timeout: ERR after 256 wait cycles, sticky until reset.
    mem_req = 1'b1;
    tick(255);
    check("to_pre_state", state, 1);
    check("to_pre_mem_err", mem_err, 0);
    tick(1);
    check("to_state", state, 2);
    check("to_mem_err", mem_err, 1);
    mem_req = 1'b0; mem_ack = 1'b1; ex_branch_taken = 1'b1; #1;
    check("err_pc_stall", pc_stall, 1);
    check("err_ex_mem_stall", ex_mem_stall, 1);
    check("err_if_id_flush", if_id_flush, 0);
    check("err_mem_wb_flush", mem_wb_flush, 1);
    tick(3);
    check("err_sticky_state", state, 2);
    reset = 1'b1; #1;
    check("err_rst_state", state, 0);
    check("err_rst_mem_err", mem_err, 0);
    check("err_rst_stall_cnt", stall_cnt, 0);
    tick(1); reset = 1'b0; idle();
    tick(1);

    // Saturation after 65540 stall cycles.
    load_use_pat(5'd9);
    tick(65540);
    check("sat_stall_cnt", stall_cnt, 16'hFFFF);
    check("sat_pc_stall", pc_stall, 1);
    idle();
    tick(2);
    check("sat_hold", stall_cnt, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
